spectrum_frame_buffer: RTL and testbench
========================================

SPECTRUM_FRAME_BUFFER -- requirements
Module: spectrum_frame_buffer

Interface
REQ-001 Parameter N_POINTS, default 512: FFT points per frame; SHALL be a power of two.
REQ-002 Parameter DW, default 9: magnitude sample width.
REQ-003 Port clk, input, 1: single clock domain shared by FFT stream and display request side.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port fft_data, input, DW: magnitude sample.
REQ-006 Port fft_valid, input, 1: fft_data valid this cycle.
REQ-007 Port fft_eop, input, 1: qualified by fft_valid; marks the last sample of a frame.
REQ-008 Port frame_sync, input, 1: display vertical sync, high active; bank swap point.
REQ-009 Port data_req, input, 1: one-cycle pulse from the display; advance to the next spectrum point.
REQ-010 Port fft_point_done, input, 1: one-cycle pulse at end of display line; rewind the point counter.
REQ-011 Port fft_point_cnt, output, log2(N_POINTS): current read point index.
REQ-012 Port ram_data_out, output, DW: magnitude at fft_point_cnt from the display bank.
REQ-013 Port frame_ready, output, 1: a committed frame is waiting for swap.
REQ-014 Port drop_cnt, output, 8: count of discarded input frames, saturating at 255.

Function
REQ-015 Storage SHALL be two banks of N_POINTS x DW (ping-pong); the write bank and the read bank SHALL always differ.
REQ-016 Write FSM states SHALL be IDLE, FILL, HOLD, SKIP.
REQ-017 IDLE: on fft_valid, write sample to write-bank address 0, set wr_idx=1, go FILL; if fft_eop is also set, treat the frame as short (REQ-019).
REQ-018 FILL: each fft_valid writes to address wr_idx, wr_idx+1; fft_eop with the N_POINTS-th sample (wr_idx==N_POINTS-1) SHALL commit the frame: frame_ready<=1, go HOLD.
REQ-019 FILL: fft_eop before the N_POINTS-th sample SHALL discard the frame, drop_cnt+1, go IDLE.
REQ-020 FILL: the N_POINTS-th sample without fft_eop SHALL discard the frame, drop_cnt+1, go SKIP; SKIP ignores data until a valid fft_eop, then goes IDLE.
REQ-021 HOLD: incoming frames SHALL not be written; each fft_eop seen SHALL increment drop_cnt; the state remains HOLD until swap.
REQ-022 Swap SHALL occur on the clock after a rising edge of frame_sync, detected against a registered copy, only while frame_ready=1: toggle bank select, frame_ready<=0, write FSM to IDLE, or to SKIP if a frame is mid-stream (fft_valid seen since the last eop).
REQ-023 A rising frame_sync with frame_ready=0 SHALL cause no swap; the display repeats the previous frame.
REQ-024 The read counter SHALL increment fft_point_cnt by 1 per data_req pulse and saturate at N_POINTS-1.
REQ-025 fft_point_done SHALL set fft_point_cnt to 0; simultaneous data_req and fft_point_done SHALL yield 0.
REQ-026 ram_data_out SHALL equal read-bank[fft_point_cnt] with exactly one clock of latency after fft_point_cnt or the bank select changes (registered synchronous RAM read).
REQ-027 A swap SHALL also reset fft_point_cnt to 0.
REQ-028 A sample write and a data read in the same cycle SHALL not conflict (different banks).

Reset
REQ-029 While rst=1: fft_point_cnt=0, ram_data_out=0, frame_ready=0, drop_cnt=0, bank select=0 (write bank 0, read bank 1), FSM=IDLE, frame_sync history=0.
REQ-030 RAM contents SHALL be undefined after reset; a mid-frame reset SHALL abandon the frame, with no commit.
REQ-031 The first swap after reset SHALL present only a fully committed frame.

Verification
REQ-032 512 valid samples of value i mod 512 with eop on the last, then a frame_sync rise -> frame_ready 1 then 0; after 3 data_req pulses fft_point_cnt=3 and ram_data_out=3 one cycle later.
REQ-033 A frame with eop on sample 300 -> drop_cnt=1, frame_ready stays 0, no swap on frame_sync.
REQ-034 Two complete frames with no frame_sync between -> drop_cnt=1; after the swap the display shows the first frame's data.
REQ-035 600 data_req pulses -> fft_point_cnt=511; data_req and fft_point_done in the same cycle -> 0.
REQ-036 rst asserted at sample 200 of a frame, then a full frame and a frame_sync -> only the new frame is displayed, drop_cnt=0.
REQ-037 Swap while a stream is mid-frame -> that frame is skipped to its eop and the next full frame commits normally.

Source files
------------

// File: rtl/spectrum_frame_buffer.sv
// Ping-pong spectrum frame store between an FFT magnitude stream
// and a display that walks the points one request at a time.
module spectrum_frame_buffer #(
  parameter int N_POINTS = 512,
  parameter int DW       = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DW-1:0]               fft_data,
  input  logic                        fft_valid,
  input  logic                        fft_eop,
  input  logic                        frame_sync,
  input  logic                        data_req,
  input  logic                        fft_point_done,
  output logic [$clog2(N_POINTS)-1:0] fft_point_cnt,
  output logic [DW-1:0]               ram_data_out,
  output logic                        frame_ready,
  output logic [7:0]                  drop_cnt
);

  localparam int AW = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    SKIP
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [2*N_POINTS];

  logic [AW-1:0] wr_idx, wr_idx_nxt, wr_addr;
  logic          we, drop, commit;
  logic          bank_sel, sync_q, mid_frame, mid_nxt, swap;

  assign swap    = frame_sync & ~sync_q & frame_ready;
  assign mid_nxt = fft_valid ? ~fft_eop : mid_frame;

  always_comb begin
    state_nxt  = state;
    wr_idx_nxt = wr_idx;
    wr_addr    = wr_idx;
    we         = 1'b0;
    drop       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fft_valid) begin
          we      = 1'b1;
          wr_addr = '0;
          if (fft_eop) begin
            drop = 1'b1;
          end else begin
            wr_idx_nxt = AW'(1);
            state_nxt  = FILL;
          end
        end
      end
      FILL: begin
        if (fft_valid) begin
          we         = 1'b1;
          wr_idx_nxt = wr_idx + 1'b1;
          if (wr_idx == LAST) begin
            if (fft_eop) begin
              commit    = 1'b1;
              state_nxt = HOLD;
            end else begin
              drop      = 1'b1;
              state_nxt = SKIP;
            end
          end else if (fft_eop) begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        drop = fft_valid & fft_eop;
      end
      SKIP: begin
        if (fft_valid && fft_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A swap abandons whatever frame is in flight on the input side
    if (swap) state_nxt = mid_nxt ? SKIP : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      frame_ready <= 1'b0;
      drop_cnt    <= '0;
      bank_sel    <= 1'b0;
      sync_q      <= 1'b0;
      mid_frame   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_idx    <= wr_idx_nxt;
      sync_q    <= frame_sync;
      mid_frame <= mid_nxt;
      if (swap) begin
        bank_sel    <= ~bank_sel;
        frame_ready <= 1'b0;
      end else if (commit) begin
        frame_ready <= 1'b1;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fft_point_cnt <= '0;
    end else if (fft_point_done || swap) begin
      fft_point_cnt <= '0;
    end else if (data_req && fft_point_cnt != LAST) begin
      fft_point_cnt <= fft_point_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{bank_sel, wr_addr}] <= fft_data;
  end

  always_ff @(posedge clk) begin
    if (rst) ram_data_out <= '0;
    else     ram_data_out <= mem[{~bank_sel, fft_point_cnt}];
  end

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Directed bench for spectrum_frame_buffer at the default
// 512-point, 9-bit configuration.
module tb_spectrum_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] fft_data;
  logic       fft_valid;
  logic       fft_eop;
  logic       frame_sync;
  logic       data_req;
  logic       fft_point_done;
  logic [8:0] fft_point_cnt;
  logic [8:0] ram_data_out;
  logic       frame_ready;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  spectrum_frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .fft_data      (fft_data),
    .fft_valid     (fft_valid),
    .fft_eop       (fft_eop),
    .frame_sync    (frame_sync),
    .data_req      (data_req),
    .fft_point_done(fft_point_done),
    .fft_point_cnt (fft_point_cnt),
    .ram_data_out  (ram_data_out),
    .frame_ready   (frame_ready),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input int first, input int last,
                      input int eop_at);
    for (int i = first; i <= last; i++) begin
      fft_valid = 1'b1;
      fft_data  = 9'((base + i) % 512);
      fft_eop   = (i == eop_at);
      step();
    end
    fft_valid = 1'b0;
    fft_eop   = 1'b0;
  endtask

  task automatic vsync();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    step();
  endtask

  task automatic req(input int n);
    for (int i = 0; i < n; i++) begin
      data_req = 1'b1;
      step();
      data_req = 1'b0;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    fft_data = '0;
    fft_valid = 1'b0;
    fft_eop = 1'b0;
    frame_sync = 1'b0;
    data_req = 1'b0;
    fft_point_done = 1'b0;
    step();
    step();
    chk("rst_cnt", 32'(fft_point_cnt), 0);
    chk("rst_ram", 32'(ram_data_out), 0);
    chk("rst_ready", 32'(frame_ready), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b0;
    step();

    // full frame A: value i
    send(0, 0, 511, 511);
    chk("a_ready", 32'(frame_ready), 1);
    vsync();
    chk("a_ready_clr", 32'(frame_ready), 0);
    chk("a_cnt0", 32'(fft_point_cnt), 0);
    chk("a_ram0", 32'(ram_data_out), 0);
    req(3);
    chk("a_cnt3", 32'(fft_point_cnt), 3);
    chk("a_ram3", 32'(ram_data_out), 3);

    req(600);
    chk("sat_cnt", 32'(fft_point_cnt), 511);
    chk("sat_ram", 32'(ram_data_out), 511);
    data_req = 1'b1;
    fft_point_done = 1'b1;
    step();
    data_req = 1'b0;
    fft_point_done = 1'b0;
    step();
    chk("rewind_cnt", 32'(fft_point_cnt), 0);
    chk("rewind_ram", 32'(ram_data_out), 0);

    // short frame: eop on sample 300
    send(50, 0, 299, 299);
    chk("short_drop", 32'(drop_cnt), 1);
    chk("short_ready", 32'(frame_ready), 0);
    req(5);
    vsync();
    chk("noswap_cnt", 32'(fft_point_cnt), 5);
    chk("noswap_ram", 32'(ram_data_out), 5);

    // frames B and C back to back, C is dropped
    send(100, 0, 511, 511);
    send(200, 0, 511, 511);
    chk("bc_drop", 32'(drop_cnt), 2);
    chk("bc_ready", 32'(frame_ready), 1);
    vsync();
    chk("b_cnt0", 32'(fft_point_cnt), 0);
    chk("b_ram0", 32'(ram_data_out), 100);
    req(7);
    chk("b_ram7", 32'(ram_data_out), 107);

    // frame D committed, then swap while E is mid-stream
    send(300, 0, 511, 511);
    chk("d_ready", 32'(frame_ready), 1);
    send(350, 0, 49, -1);
    vsync();
    chk("d_cnt0", 32'(fft_point_cnt), 0);
    chk("d_ram0", 32'(ram_data_out), 300);
    chk("d_ready_clr", 32'(frame_ready), 0);
    send(350, 50, 511, 511);
    chk("e_skip_ready", 32'(frame_ready), 0);
    chk("e_skip_drop", 32'(drop_cnt), 2);
    send(400, 0, 511, 511);
    chk("f_ready", 32'(frame_ready), 1);
    vsync();
    req(2);
    chk("f_ram2", 32'(ram_data_out), 402);

    // drop counter saturation using one-sample frames
    fft_valid = 1'b1;
    fft_eop = 1'b1;
    for (int i = 0; i < 260; i++) step();
    fft_valid = 1'b0;
    fft_eop = 1'b0;
    step();
    chk("drop_sat", 32'(drop_cnt), 255);

    // reset in the middle of frame G, then full frame H
    send(450, 0, 199, -1);
    rst = 1'b1;
    step();
    step();
    chk("mrst_drop", 32'(drop_cnt), 0);
    chk("mrst_ready", 32'(frame_ready), 0);
    chk("mrst_cnt", 32'(fft_point_cnt), 0);
    rst = 1'b0;
    step();
    send(37, 0, 511, 511);
    chk("h_ready", 32'(frame_ready), 1);
    vsync();
    chk("h_ram0", 32'(ram_data_out), 37);
    req(10);
    chk("h_cnt10", 32'(fft_point_cnt), 10);
    chk("h_ram10", 32'(ram_data_out), 47);
    chk("h_drop", 32'(drop_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
